// File: rtl/mau_pkg.sv
// mau_pkg
// Shared definitions for the memory access unit: FSM state encodings,
// load/store opcode constants and default datapath widths.
// Optional feature macro used by the unit: MAU_ALIGN_CHECK_EN.
package mau_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 5;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        CDB   = 2'd2,
        DRAIN = 2'd3
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the load/store-queue issue port, the data-memory port, the CDB
// broadcast port, store completion, ROB flush and the busy flag.
//   slave  : view used by mem_access_unit
//   master : view used by the surrounding pipeline / environment
interface mem_access_unit_if
    import mau_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) ();

    // Load/store queue head
    logic              lsq_ready;
    logic [ADDR_W-1:0] lsq_addr;
    logic [DATA_W-1:0] lsq_wdata;
    logic              lsq_opcode;
    logic [TAG_W-1:0]  lsq_rd_tag;
    logic              lsq_issue;

    // Data memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Common data bus
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_out_valid;
    logic [TAG_W-1:0]  cdb_out_tag;
    logic [DATA_W-1:0] cdb_out_data;
    logic              cdb_out_exc;

    // Store completion, flush and status
    logic              store_done;
    logic              store_exc;
    logic              flush_valid;
    logic              busy;

    modport slave (
        input  lsq_ready, lsq_addr, lsq_wdata, lsq_opcode, lsq_rd_tag,
        output lsq_issue,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output cdb_req,
        input  cdb_grant,
        output cdb_out_valid, cdb_out_tag, cdb_out_data, cdb_out_exc,
        output store_done, store_exc,
        input  flush_valid,
        output busy
    );

    modport master (
        output lsq_ready, lsq_addr, lsq_wdata, lsq_opcode, lsq_rd_tag,
        input  lsq_issue,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  cdb_req,
        output cdb_grant,
        input  cdb_out_valid, cdb_out_tag, cdb_out_data, cdb_out_exc,
        input  store_done, store_exc,
        output flush_valid,
        input  busy
    );

endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Execution stage behind the load/store queue. Accepts one load or store
// at a time, performs the data-memory access, then either broadcasts the
// load result on the CDB (request/grant) or pulses store completion.
// A ROB flush discards in-flight loads; stores always complete.
// Ports:
//   clock  : clock
//   nreset : asynchronous active-low reset
//   bus    : mem_access_unit_if.slave (LSQ, memory, CDB, store, flush, busy)
// Configuration macro: MAU_ALIGN_CHECK_EN -- when defined, a misaligned
// address skips memory and reports an exception; when undefined the low
// address bits are ignored and the exception outputs are tied low.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic               clock,
    input logic               nreset,
    mem_access_unit_if.slave  bus
);

    mau_state_t        r_state;
    mau_state_t        w_nextState;
    logic [ADDR_W-3:0] r_wordAddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_opcode;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_rdata;
    logic              r_storeDone;
    logic              w_storeDoneNext;
    logic              w_issue;
    logic              w_memReq;
    logic              w_cdbReq;
    logic              w_cdbValid;
    logic              w_misaligned;

`ifdef MAU_ALIGN_CHECK_EN
    logic              r_exc;
    logic              r_storeExc;
    logic              w_storeExcNext;
    assign w_misaligned = (bus.lsq_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue    = (r_state == IDLE) && bus.lsq_ready && !bus.flush_valid;
    assign w_memReq   = (r_state == MEM) || (r_state == DRAIN);
    assign w_cdbReq   = (r_state == CDB) && !bus.flush_valid;
    assign w_cdbValid = w_cdbReq && bus.cdb_grant;

    always_comb begin
        w_nextState     = r_state;
        w_storeDoneNext = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
        w_storeExcNext  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (w_misaligned) begin
                        // Misaligned ops never touch memory: loads report via
                        // the CDB, stores complete immediately with an exception.
                        if (bus.lsq_opcode == OP_LOAD) begin
                            w_nextState = CDB;
                        end else begin
                            w_nextState     = IDLE;
                            w_storeDoneNext = 1'b1;
`ifdef MAU_ALIGN_CHECK_EN
                            w_storeExcNext  = 1'b1;
`endif
                        end
                    end else begin
                        w_nextState = MEM;
                    end
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    if (r_opcode == OP_STORE) begin
                        w_storeDoneNext = 1'b1;
                        w_nextState     = IDLE;
                    end else begin
                        // A flush arriving with the ack already has its access
                        // finished, so there is nothing left to drain.
                        w_nextState = bus.flush_valid ? IDLE : CDB;
                    end
                end else if (bus.flush_valid && (r_opcode == OP_LOAD)) begin
                    w_nextState = DRAIN;
                end
            end
            CDB: begin
                if (bus.flush_valid || bus.cdb_grant) begin
                    w_nextState = IDLE;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= IDLE;
            r_wordAddr  <= '0;
            r_wdata     <= '0;
            r_opcode    <= 1'b0;
            r_tag       <= '0;
            r_rdata     <= '0;
            r_storeDone <= 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
            r_exc       <= 1'b0;
            r_storeExc  <= 1'b0;
`endif
        end else begin
            r_state     <= w_nextState;
            r_storeDone <= w_storeDoneNext;
`ifdef MAU_ALIGN_CHECK_EN
            r_storeExc  <= w_storeExcNext;
`endif
            if (w_issue) begin
                r_wordAddr <= bus.lsq_addr[ADDR_W-1:2];
                r_wdata    <= bus.lsq_wdata;
                r_opcode   <= bus.lsq_opcode;
                r_tag      <= bus.lsq_rd_tag;
                // Cleared so a misaligned load broadcasts zero data.
                r_rdata    <= '0;
`ifdef MAU_ALIGN_CHECK_EN
                r_exc      <= w_misaligned;
`endif
            end
            if ((r_state == MEM) && bus.mem_ack && (r_opcode == OP_LOAD)) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.lsq_issue     = w_issue;
    assign bus.mem_req       = w_memReq;
    assign bus.mem_we        = w_memReq && (r_opcode == OP_STORE);
    assign bus.mem_addr      = w_memReq ? {r_wordAddr, 2'b00} : '0;
    assign bus.mem_wdata     = (w_memReq && (r_opcode == OP_STORE)) ? r_wdata : '0;
    assign bus.cdb_req       = w_cdbReq;
    assign bus.cdb_out_valid = w_cdbValid;
    assign bus.cdb_out_tag   = w_cdbValid ? r_tag : '0;
    assign bus.cdb_out_data  = w_cdbValid ? r_rdata : '0;
    assign bus.store_done    = r_storeDone;
    assign bus.busy          = (r_state != IDLE);
`ifdef MAU_ALIGN_CHECK_EN
    assign bus.cdb_out_exc   = w_cdbValid && r_exc;
    assign bus.store_exc     = r_storeExc;
`else
    assign bus.cdb_out_exc   = 1'b0;
    assign bus.store_exc     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: a table of directed transactions,
// randomized transactions checked against a transaction-level model, and
// hand-written sequences for flush, reset and ignored-handshake corners.
// Honours MAU_ALIGN_CHECK_EN for the misaligned-address expectations.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic clock = 1'b0;
    logic nreset;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        isStore;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  tag;
        int          ackWait;
        int          grantWait;
        logic        expMem;
        logic [31:0] expMemAddr;
        logic [31:0] expData;
        logic        expExc;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic vec_t mkVec(input logic isStore, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input logic [4:0] tag, input int ackWait,
                                   input int grantWait, input logic expMem,
                                   input logic [31:0] expMemAddr,
                                   input logic [31:0] expData, input logic expExc);
        vec_t v;
        v.isStore = isStore;   v.addr = addr;         v.wdata = wdata;
        v.rdata = rdata;       v.tag = tag;           v.ackWait = ackWait;
        v.grantWait = grantWait; v.expMem = expMem;   v.expMemAddr = expMemAddr;
        v.expData = expData;   v.expExc = expExc;
        return v;
    endfunction

    // Transaction-level reference: word address by integer division,
    // misaligned ops (when checking is enabled) bypass memory with an exception.
    function automatic vec_t modelExpect(input vec_t v);
        vec_t r;
        logic alignCheck;
        r = v;
`ifdef MAU_ALIGN_CHECK_EN
        alignCheck = 1'b1;
`else
        alignCheck = 1'b0;
`endif
        r.expMem     = !(alignCheck && (v.addr % 4 != 0));
        r.expMemAddr = (v.addr / 4) * 4;
        r.expData    = r.expMem ? v.rdata : 32'h0;
        r.expExc     = !r.expMem;
        return r;
    endfunction

    task automatic idleInputs();
        bus.lsq_ready   = 1'b0;
        bus.lsq_addr    = '0;
        bus.lsq_wdata   = '0;
        bus.lsq_opcode  = 1'b0;
        bus.lsq_rd_tag  = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.cdb_grant   = 1'b0;
        bus.flush_valid = 1'b0;
    endtask

    task automatic issueOp(input logic isStore, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag);
        bus.lsq_ready  = 1'b1;
        bus.lsq_addr   = addr;
        bus.lsq_wdata  = wdata;
        bus.lsq_opcode = isStore;
        bus.lsq_rd_tag = tag;
        settle();
        checkOutput("lsq_issue", bus.lsq_issue, 1);
        tick();
        bus.lsq_ready = 1'b0;
    endtask

    // Runs one full transaction, checking every cycle of it.
    task automatic applyStimulus(input vec_t v);
        issueOp(v.isStore, v.addr, v.wdata, v.tag);
        if (v.expMem) begin
            for (int w = 0; w <= v.ackWait; w++) begin
                bus.lsq_ready = 1'b1;
                bus.mem_ack   = (w == v.ackWait);
                bus.mem_rdata = v.rdata;
                settle();
                checkOutput("mem_req", bus.mem_req, 1);
                checkOutput("mem_we", bus.mem_we, v.isStore);
                checkOutput("mem_addr", bus.mem_addr, v.expMemAddr);
                if (v.isStore) checkOutput("mem_wdata", bus.mem_wdata, v.wdata);
                checkOutput("issue_blocked", bus.lsq_issue, 0);
                checkOutput("cdb_req_in_mem", bus.cdb_req, 0);
                tick();
                bus.lsq_ready = 1'b0;
            end
            bus.mem_ack = 1'b0;
        end else begin
            settle();
            checkOutput("no_mem_req", bus.mem_req, 0);
        end
        if (v.isStore) begin
            settle();
            checkOutput("store_done", bus.store_done, 1);
            checkOutput("store_exc", bus.store_exc, v.expExc);
            checkOutput("store_cdb_req", bus.cdb_req, 0);
            checkOutput("store_busy", bus.busy, 0);
            tick();
            checkOutput("store_done_end", bus.store_done, 0);
        end else begin
            for (int g = 0; g <= v.grantWait; g++) begin
                bus.cdb_grant = (g == v.grantWait);
                settle();
                checkOutput("cdb_req", bus.cdb_req, 1);
                checkOutput("cdb_valid", bus.cdb_out_valid, (g == v.grantWait));
                checkOutput("cdb_tag", bus.cdb_out_tag, (g == v.grantWait) ? v.tag : 5'd0);
                checkOutput("cdb_data", bus.cdb_out_data, (g == v.grantWait) ? v.expData : 32'h0);
                checkOutput("cdb_exc", bus.cdb_out_exc, (g == v.grantWait) ? v.expExc : 1'b0);
                tick();
            end
            bus.cdb_grant = 1'b0;
            settle();
            checkOutput("cdb_single_bcast", bus.cdb_out_valid, 0);
            checkOutput("load_busy", bus.busy, 0);
        end
    endtask

    vec_t table_q[$];
    vec_t rv;

    initial begin
        idleInputs();
        nreset = 1'b0;
        #12;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_mem_req", bus.mem_req, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_cdb_req", bus.cdb_req, 0);
        checkOutput("rst_cdb_valid", bus.cdb_out_valid, 0);
        checkOutput("rst_store_done", bus.store_done, 0);
        checkOutput("rst_issue", bus.lsq_issue, 0);
        nreset = 1'b1;
        tick();

        // Directed table
        table_q.push_back(mkVec(0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 0, 0,
                                1, 32'h100, 32'hDEADBEEF, 0));
        table_q.push_back(mkVec(1, 32'h204, 32'h55, 32'h0, 5'd2, 3, 0,
                                1, 32'h204, 32'h0, 0));
        table_q.push_back(mkVec(0, 32'h3F0, 32'h0, 32'h12345678, 5'd31, 1, 5,
                                1, 32'h3F0, 32'h12345678, 0));
        table_q.push_back(mkVec(1, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h0, 5'd0, 0, 0,
                                1, 32'hFFFFFFFC, 32'h0, 0));
`ifdef MAU_ALIGN_CHECK_EN
        table_q.push_back(mkVec(0, 32'h102, 32'h0, 32'hCAFEF00D, 5'd3, 0, 0,
                                0, 32'h0, 32'h0, 1));
        table_q.push_back(mkVec(1, 32'h7, 32'h99, 32'h0, 5'd4, 0, 0,
                                0, 32'h0, 32'h0, 1));
`else
        table_q.push_back(mkVec(0, 32'h102, 32'h0, 32'hCAFEF00D, 5'd3, 0, 0,
                                1, 32'h100, 32'hCAFEF00D, 0));
        table_q.push_back(mkVec(1, 32'h7, 32'h99, 32'h0, 5'd4, 0, 0,
                                1, 32'h4, 32'h0, 0));
`endif
        foreach (table_q[i]) applyStimulus(table_q[i]);

        // Randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            rv.isStore   = 1'($urandom_range(0, 1));
            rv.addr      = $urandom;
            rv.wdata     = $urandom;
            rv.rdata     = $urandom;
            rv.tag       = 5'($urandom_range(0, 31));
            rv.ackWait   = $urandom_range(0, 3);
            rv.grantWait = $urandom_range(0, 3);
            applyStimulus(modelExpect(rv));
        end

        // mem_ack and cdb_grant while idle are ignored
        bus.mem_ack = 1'b1;
        bus.cdb_grant = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.cdb_grant = 1'b0;
        settle();
        checkOutput("stray_busy", bus.busy, 0);
        checkOutput("stray_valid", bus.cdb_out_valid, 0);
        checkOutput("stray_store_done", bus.store_done, 0);

        // Flush in IDLE suppresses issue
        bus.lsq_ready = 1'b1;
        bus.flush_valid = 1'b1;
        settle();
        checkOutput("flush_idle_issue", bus.lsq_issue, 0);
        tick();
        idleInputs();
        settle();
        checkOutput("flush_idle_busy", bus.busy, 0);

        // Flush during load MEM: drain, no broadcast, issue blocked meanwhile
        issueOp(0, 32'h40, 32'h0, 5'd9);
        bus.flush_valid = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        bus.lsq_ready = 1'b1;
        settle();
        checkOutput("drain_mem_req", bus.mem_req, 1);
        checkOutput("drain_issue", bus.lsq_issue, 0);
        tick();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h11112222;
        settle();
        checkOutput("drain_ack_req", bus.mem_req, 1);
        checkOutput("drain_cdb_req", bus.cdb_req, 0);
        tick();
        idleInputs();
        settle();
        checkOutput("drain_done_busy", bus.busy, 0);
        checkOutput("drain_no_cdb", bus.cdb_req, 0);

        // Flush during store MEM: store still completes
        issueOp(1, 32'h80, 32'h77, 5'd1);
        bus.flush_valid = 1'b1;
        bus.mem_ack = 1'b1;
        settle();
        checkOutput("fstore_mem_req", bus.mem_req, 1);
        tick();
        idleInputs();
        settle();
        checkOutput("fstore_done", bus.store_done, 1);
        tick();

        // Flush in the grant cycle: no broadcast
        issueOp(0, 32'hC0, 32'h0, 5'd12);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.mem_ack = 1'b0;
        bus.flush_valid = 1'b1;
        bus.cdb_grant = 1'b1;
        settle();
        checkOutput("fgrant_cdb_req", bus.cdb_req, 0);
        checkOutput("fgrant_valid", bus.cdb_out_valid, 0);
        checkOutput("fgrant_data", bus.cdb_out_data, 0);
        tick();
        idleInputs();
        settle();
        checkOutput("fgrant_busy", bus.busy, 0);

        // Reset in the middle of an access abandons it
        issueOp(0, 32'h200, 32'h0, 5'd5);
        nreset = 1'b0;
        settle();
        checkOutput("midrst_mem_req", bus.mem_req, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        #2;
        nreset = 1'b1;
        tick();
        settle();
        checkOutput("midrst_after_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
